hazard_scheduler: RTL and testbench

- Central stall/flush/forward controller for the 5-stage RISC-V pipeline.
- Detects load-use hazards, branch/jump redirects and data-memory wait states.
- Drives the Stall/Flush controls of the IF/ID, ID/EX and EX/MEM registers and the EX-stage forwarding selects.
- Holds a memory-wait FSM with timeout and optional performance counters.

---
 rtl/hazard_scheduler.sv | 160 ++++++++++++++++
 tb/tb_hazard_scheduler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Stall/flush/forward controller for the 5-stage pipeline with memory-wait FSM.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_scheduler #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic [1:0]       ResultSrc_E,
  input  logic             PCSrc_E,
  input  logic             MemReq_M,
  input  logic             MemReady_M,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [0:0]  S_RUN  = 1'b0;
  localparam logic [0:0]  S_WAIT = 1'b1;
  localparam logic [15:0] TO_MAX = 16'(MEM_TIMEOUT);

  logic [0:0]  r_state;
  logic [15:0] r_wcnt;
  logic        r_timeout;
  logic        w_force;
  logic        w_memwait;
  logic        w_lwstall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w
  );
    if (we_m && rd_m != 5'd0 && rd_m == rs)
      return 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // r_wcnt holds the number of frozen cycles already spent in this wait
  assign w_force   = (r_state == S_WAIT) && (r_wcnt == TO_MAX);
  assign w_memwait = MemReq_M && !MemReady_M && !w_force;
  assign w_lwstall = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                     ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  always_comb begin
    Stall_F    = 1'b0;
    Stall_D    = 1'b0;
    Stall_E    = 1'b0;
    Stall_M    = 1'b0;
    Flush_D    = 1'b0;
    Flush_E    = 1'b0;
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    if (rst) begin
      ForwardA_E = fwd_sel(Rs1_E, RegWrite_M, Rd_M,
                           RegWrite_W, Rd_W);
      ForwardB_E = fwd_sel(Rs2_E, RegWrite_M, Rd_M,
                           RegWrite_W, Rd_W);
      if (w_memwait) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        Stall_M = 1'b1;
      end else if (PCSrc_E) begin
        Flush_D = 1'b1;
        Flush_E = 1'b1;
      end else if (w_lwstall) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_RUN;
      r_wcnt    <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_memwait) begin
            r_state <= S_WAIT;
            r_wcnt  <= 16'd1;
          end
        end
        S_WAIT: begin
          if (MemReady_M || !MemReq_M) begin
            r_state <= S_RUN;
            r_wcnt  <= 16'd0;
          end else if (w_force) begin
            r_state   <= S_RUN;
            r_timeout <= 1'b1;
            r_wcnt    <= 16'd0;
          end else begin
            r_wcnt <= r_wcnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_RUN;
          r_wcnt  <= 16'd0;
        end
      endcase
    end
  end

  assign MemTimeout = r_timeout;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_scnt;
  logic [CNT_W-1:0] r_fcnt;
  logic             w_any_stall;
  logic             w_any_flush;

  assign w_any_stall = Stall_F | Stall_D | Stall_E | Stall_M;
  assign w_any_flush = Flush_D | Flush_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scnt <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_any_stall && r_scnt != '1)
        r_scnt <= r_scnt + CNT_W'(1);
      if (w_any_flush && r_fcnt != '1)
        r_fcnt <= r_fcnt + CNT_W'(1);
    end
  end

  assign StallCount = r_scnt;
  assign FlushCount = r_fcnt;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_hazard_scheduler;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic          RegWrite_M, RegWrite_W;
  logic [1:0]    ResultSrc_E;
  logic          PCSrc_E, MemReq_M, MemReady_M;
  logic          Stall_F, Stall_D, Stall_E, Stall_M;
  logic          Flush_D, Flush_E;
  logic [1:0]    ForwardA_E, ForwardB_E;
  logic          MemTimeout;
  logic [CW-1:0] StallCount, FlushCount;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_frozen = 0;
  bit m_to     = 1'b0;
  int m_sc     = 0;
  int m_fc     = 0;

  logic [9:0]    exp_c;
  logic [2*CW:0] exp_s;
  wire  [9:0]    act_c = {Stall_F, Stall_D, Stall_E, Stall_M,
                          Flush_D, Flush_E, ForwardA_E, ForwardB_E};
  wire  [2*CW:0] act_s = {MemTimeout, StallCount, FlushCount};

  always #5 clk = ~clk;

  hazard_scheduler #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .Rd_M(Rd_M), .Rd_W(Rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
    .MemReq_M(MemReq_M), .MemReady_M(MemReady_M),
    .Stall_F(Stall_F), .Stall_D(Stall_D),
    .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .MemTimeout(MemTimeout),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
    if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // a wait may freeze the pipe for at most TO consecutive cycles
  function automatic logic ref_memwait();
    return rst && MemReq_M && !MemReady_M && (m_frozen < TO);
  endfunction

  function automatic logic [9:0] ref_ctrl();
    logic       lw;
    logic [5:0] c;
    if (!rst) return '0;
    lw = (ResultSrc_E == 2'b01) && (Rd_E != 0) &&
         ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
    if (ref_memwait())  c = 6'b111100;
    else if (PCSrc_E)   c = 6'b000011;
    else if (lw)        c = 6'b110001;
    else                c = 6'b000000;
    return {c, ref_fwd(Rs1_E), ref_fwd(Rs2_E)};
  endfunction

  function automatic logic [2*CW:0] ref_status();
`ifdef HAZARD_PERF_EN
    return {m_to, CW'(m_sc), CW'(m_fc)};
`else
    return {m_to, {(2*CW){1'b0}}};
`endif
  endfunction

  task automatic model_reset();
    m_frozen = 0;
    m_to     = 1'b0;
    m_sc     = 0;
    m_fc     = 0;
  endtask

  task automatic tick();
    logic [9:0] c;
    logic       mw, stuck;
    c     = ref_ctrl();
    mw    = ref_memwait();
    stuck = rst && MemReq_M && !MemReady_M && !mw;
    @(posedge clk);
    if (rst) begin
      if (mw) m_frozen++;
      else    m_frozen = 0;
      if (stuck) m_to = 1'b1;
      if (|c[9:6]) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (|c[5:4]) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    end
    #1;
  endtask

  task automatic idle();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
    Rd_E = 0; Rd_M = 0; Rd_W = 0;
    RegWrite_M = 0; RegWrite_W = 0; ResultSrc_E = 0;
    PCSrc_E = 0; MemReq_M = 0; MemReady_M = 0;
  endtask

  task automatic rand_in();
    Rs1_D = 5'($urandom_range(0, 3));
    Rs2_D = 5'($urandom_range(0, 3));
    Rs1_E = 5'($urandom_range(0, 3));
    Rs2_E = 5'($urandom_range(0, 3));
    Rd_E  = 5'($urandom_range(0, 3));
    Rd_M  = 5'($urandom_range(0, 3));
    Rd_W  = 5'($urandom_range(0, 3));
    RegWrite_M  = 1'($urandom_range(0, 1));
    RegWrite_W  = 1'($urandom_range(0, 1));
    ResultSrc_E = 2'($urandom_range(0, 3));
    PCSrc_E     = ($urandom_range(0, 7) == 0);
    MemReq_M    = ($urandom_range(0, 2) != 0);
    MemReady_M  = ($urandom_range(0, 2) == 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    MemReq_M = 1; PCSrc_E = 1; Rs1_E = 3; Rd_M = 3; RegWrite_M = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_tests++;
      if (act_c !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl act=%b exp=%b", act_c, 10'b0);
      end
      n_tests++;
      if (act_s !== '0) begin
        n_fail++;
        $display("FAIL reset_status act=%h exp=0", act_s);
      end
      tick();
    end
    idle();
    rst = 1'b1;
  endtask

  task automatic test_forward();
    idle();
    Rs1_E = 5; Rd_M = 5; RegWrite_M = 1; Rd_W = 5; RegWrite_W = 1;
    #2;
    n_tests++;
    if (ForwardA_E !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_m_prio act=%b exp=10", ForwardA_E);
    end
    Rd_M = 0;
    #2;
    n_tests++;
    if (ForwardA_E !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_w act=%b exp=01", ForwardA_E);
    end
    Rs2_E = 0; Rd_W = 0; Rd_M = 3;
    #2;
    n_tests++;
    if (ForwardB_E !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_x0 act=%b exp=00", ForwardB_E);
    end
    tick();
    for (int i = 0; i < 30; i++) begin
      rand_in();
      MemReq_M = 0; PCSrc_E = 0; ResultSrc_E = 0;
      #2;
      exp_c = ref_ctrl();
      n_tests++;
      if (act_c !== exp_c) begin
        n_fail++;
        $display("FAIL fwd_rand act=%b exp=%b", act_c, exp_c);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    idle();
    ResultSrc_E = 2'b01; Rd_E = 7; Rs2_D = 7;
    #2;
    n_tests++;
    if (act_c[9:4] !== 6'b110001) begin
      n_fail++;
      $display("FAIL lw_bubble act=%b exp=110001", act_c[9:4]);
    end
    tick();
    ResultSrc_E = 2'b00;
    #2;
    n_tests++;
    if (act_c[9:4] !== 6'b000000) begin
      n_fail++;
      $display("FAIL lw_after act=%b exp=000000", act_c[9:4]);
    end
    tick();
  endtask

  task automatic test_redirect();
    idle();
    ResultSrc_E = 2'b01; Rd_E = 9; Rs1_D = 9; PCSrc_E = 1;
    #2;
    n_tests++;
    if (act_c[9:4] !== 6'b000011) begin
      n_fail++;
      $display("FAIL redirect_vs_lw act=%b exp=000011", act_c[9:4]);
    end
    tick();
    idle();
  endtask

  task automatic test_mem_wait();
    idle();
    MemReq_M = 1; MemReady_M = 0; PCSrc_E = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_tests++;
      if (act_c[9:4] !== 6'b111100) begin
        n_fail++;
        $display("FAIL memwait_c%0d act=%b exp=111100", i, act_c[9:4]);
      end
      tick();
    end
    MemReady_M = 1;
    #2;
    n_tests++;
    if (act_c[9:4] !== 6'b000011) begin
      n_fail++;
      $display("FAIL memwait_release act=%b exp=000011", act_c[9:4]);
    end
    tick();
    idle();
    #2;
    n_tests++;
    if (act_c[9:4] !== 6'b000000 || MemTimeout !== 1'b0) begin
      n_fail++;
      $display("FAIL memwait_done act=%b/%b exp=000000/0",
               act_c[9:4], MemTimeout);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [5:0] stall_seq;
    logic [5:0] to_seq;
    stall_seq = 6'b101111;
    to_seq    = 6'b100000;
    idle();
    MemReq_M = 1; MemReady_M = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_tests++;
      if (act_c[9:6] !== {4{stall_seq[i]}} || MemTimeout !== to_seq[i]) begin
        n_fail++;
        $display("FAIL timeout_c%0d stall=%b to=%b exp=%b/%b",
                 i, act_c[9:6], MemTimeout, {4{stall_seq[i]}}, to_seq[i]);
      end
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (MemTimeout !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_sticky act=%b exp=1", MemTimeout);
      end
    end
    pulse_reset();
    #2;
    n_tests++;
    if (MemTimeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear act=%b exp=0", MemTimeout);
    end
  endtask

  task automatic test_perf();
    pulse_reset();
    idle();
    ResultSrc_E = 2'b01; Rd_E = 4; Rs1_D = 4;
    for (int i = 0; i < 20; i++) tick();
    idle();
    #2;
    exp_s = ref_status();
    n_tests++;
    if (act_s !== exp_s) begin
      n_fail++;
      $display("FAIL perf_model act=%h exp=%h", act_s, exp_s);
    end
    n_tests++;
`ifdef HAZARD_PERF_EN
    if (StallCount !== 4'd15) begin
      n_fail++;
      $display("FAIL perf_sat act=%0d exp=15", StallCount);
    end
`else
    if (StallCount !== 4'd0) begin
      n_fail++;
      $display("FAIL perf_off act=%0d exp=0", StallCount);
    end
`endif
    tick();
  endtask

  task automatic test_async_reset();
    idle();
    Rs1_E = 2; Rd_M = 2; RegWrite_M = 1;
    ResultSrc_E = 2'b01; Rd_E = 6; Rs2_D = 6;
    tick();
    MemReq_M = 1; MemReady_M = 0;
    tick();
    tick();
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (act_c !== 10'b0 || act_s !== '0) begin
      n_fail++;
      $display("FAIL async_reset ctrl=%b status=%h exp=0/0", act_c, act_s);
    end
    tick();
    rst = 1'b1;
    #2;
    exp_c = ref_ctrl();
    n_tests++;
    if (act_c !== exp_c) begin
      n_fail++;
      $display("FAIL async_reenter act=%b exp=%b", act_c, exp_c);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_in();
      #2;
      exp_c = ref_ctrl();
      exp_s = ref_status();
      n_tests++;
      if (act_c !== exp_c) begin
        n_fail++;
        $display("FAIL rand_ctrl_%0d act=%b exp=%b", i, act_c, exp_c);
      end
      n_tests++;
      if (act_s !== exp_s) begin
        n_fail++;
        $display("FAIL rand_status_%0d act=%h exp=%h", i, act_s, exp_s);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_perf();
    test_async_reset();
    pulse_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
